mux_arbiter: RTL and testbench

MUX_ARBITER -- requirements
Module: mux_arbiter

---
 rtl/mux_arbiter.sv | 96 +++++++++
 tb/tb_mux_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_arbiter.sv
// mux_arbiter: two-source round-robin arbiter with a burst limit, steering
// the granted source's data onto a single shared channel.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no owner; arbitrate next edge, ties go to source != last
//   GNT0  | source 0 owns the channel, f = x1
//   GNT1  | source 1 owns the channel, f = x2
//
// A released owner always hands over to the other source or drops to IDLE,
// so one source can never hold the channel for two bursts in a row while
// the other is waiting.
module mux_arbiter #(
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic [DATA_W-1:0] x1,
  input  logic [DATA_W-1:0] x2,
  input  logic              ready,
  output logic              gnt0,
  output logic              gnt1,
  output logic              s,
  output logic [DATA_W-1:0] f,
  output logic              valid
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  // Terminal burst count: the transfer seen while cnt equals this is the last.
  localparam logic [7:0] CNT_LAST = 8'(MAX_BURST - 1);

  state_t     state;
  logic       last;
  logic [7:0] cnt;
  logic       xfer;
  logic       at_limit;

  // Grants and mux select come straight from registered state.
  assign gnt0     = (state == GNT0);
  assign gnt1     = (state == GNT1);
  assign s        = gnt1;
  assign f        = s ? x2 : x1;
  assign valid    = (gnt0 & req0) | (gnt1 & req1);
  assign xfer     = valid & ready;
  assign at_limit = (cnt == CNT_LAST);

  // Arbitration, burst counting and grant release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 8'd0;
      last  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          cnt <= 8'd0;
          if (req0 && (!req1 || last))
            state <= GNT0;
          else if (req1)
            state <= GNT1;
        end
        GNT0: begin
          if (!req0 || (xfer && at_limit)) begin
            last  <= 1'b0;
            cnt   <= 8'd0;
            state <= req1 ? GNT1 : IDLE;
          end else if (xfer) begin
            cnt <= cnt + 8'd1;
          end
        end
        GNT1: begin
          if (!req1 || (xfer && at_limit)) begin
            last  <= 1'b1;
            cnt   <= 8'd0;
            state <= req0 ? GNT0 : IDLE;
          end else if (xfer) begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_arbiter.sv
// tb_mux_arbiter: directed bench for mux_arbiter. A second instance with
// MAX_BURST=1 shares the inputs and is only checked in the burst-of-one test.
module tb_mux_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, req1, ready;
  logic [7:0] x1, x2;
  logic       gnt0, gnt1, s, valid;
  logic [7:0] f;
  logic       gnt0_b, gnt1_b, s_b, valid_b;
  logic [7:0] f_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux_arbiter #(.DATA_W(8), .MAX_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .x1(x1), .x2(x2),
    .ready(ready), .gnt0(gnt0), .gnt1(gnt1), .s(s), .f(f), .valid(valid)
  );

  mux_arbiter #(.DATA_W(8), .MAX_BURST(1)) dut_b1 (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .x1(x1), .x2(x2),
    .ready(ready), .gnt0(gnt0_b), .gnt1(gnt1_b), .s(s_b), .f(f_b), .valid(valid_b)
  );

  // Advance to just after the next rising edge (input drive point).
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Advance to the falling edge (output sample point).
  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0  = 1'b0;
    req1  = 1'b0;
    ready = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0  = 1'b1;
    req1  = 1'b1;
    ready = 1'b1;
    x1    = 8'h3C;
    x2    = 8'hC3;
    #3;
    checks++;
    if ({gnt0, gnt1, s, valid} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 0000", {gnt0, gnt1, s, valid});
    end
    checks++;
    if (f !== 8'h3C) begin
      errors++;
      $display("FAIL reset_f: got %h expected 3c", f);
    end
    req0 = 1'b0;
    req1 = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
    sample();
    checks++;
    if ({gnt0, gnt1, s, valid} !== 4'b0000 || f !== 8'h3C) begin
      errors++;
      $display("FAIL post_release: got %b f=%h expected 0000 f=3c", {gnt0, gnt1, s, valid}, f);
    end
    cycle();
  endtask

  task automatic test_alternate();
    logic e0;
    do_reset();
    req0 = 1'b1;
    req1 = 1'b1;
    ready = 1'b1;
    x1 = 8'h11;
    x2 = 8'h22;
    sample();
    checks++;
    if ({gnt0, gnt1, valid} !== 3'b000) begin
      errors++;
      $display("FAIL alt_first_idle: got %b expected 000", {gnt0, gnt1, valid});
    end
    for (int i = 0; i < 16; i++) begin
      cycle();
      x1 = 8'(i);
      x2 = 8'(i + 100);
      sample();
      e0 = (((i / 4) % 2) == 0);
      checks++;
      if ({gnt0, gnt1, s, valid} !== {e0, ~e0, ~e0, 1'b1} || f !== (e0 ? x1 : x2)) begin
        errors++;
        $display("FAIL alt_cycle%0d: got g0g1sv=%b f=%h expected %b f=%h", i,
                 {gnt0, gnt1, s, valid}, f, {e0, ~e0, ~e0, 1'b1}, (e0 ? x1 : x2));
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    req0 = 1'b1;
    ready = 1'b1;
    x1 = 8'h5A;
    x2 = 8'h00;
    cycle();
    for (int k = 1; k <= 9; k++) begin
      ready = (k == 1 || k >= 7);
      x2 = 8'(k * 17);
      sample();
      checks++;
      if ({gnt0, gnt1, valid} !== 3'b101 || f !== 8'h5A) begin
        errors++;
        $display("FAIL bp_cycle%0d: got g0g1v=%b f=%h expected 101 f=5a", k, {gnt0, gnt1, valid}, f);
      end
      cycle();
    end
    req0 = 1'b0;
    sample();
    checks++;
    if ({gnt0, gnt1, valid} !== 3'b000) begin
      errors++;
      $display("FAIL bp_release: got %b expected 000", {gnt0, gnt1, valid});
    end
  endtask

  task automatic test_req1_only();
    do_reset();
    req1 = 1'b1;
    ready = 1'b1;
    x1 = 8'h3C;
    x2 = 8'hA5;
    sample();
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL r1_latency: got valid=%b expected 0", valid);
    end
    cycle();
    sample();
    checks++;
    if ({gnt1, s, valid} !== 3'b111 || f !== 8'hA5) begin
      errors++;
      $display("FAIL r1_grant: got g1sv=%b f=%h expected 111 f=a5", {gnt1, s, valid}, f);
    end
    cycle();
    req1 = 1'b0;
    sample();
    checks++;
    if ({gnt1, valid} !== 2'b10) begin
      errors++;
      $display("FAIL r1_drop: got g1v=%b expected 10", {gnt1, valid});
    end
    cycle();
    sample();
    checks++;
    if ({gnt0, gnt1, s, valid} !== 4'b0000) begin
      errors++;
      $display("FAIL r1_idle: got %b expected 0000", {gnt0, gnt1, s, valid});
    end
  endtask

  task automatic test_handoff();
    do_reset();
    req1 = 1'b1;
    ready = 1'b0;
    cycle();
    cycle();
    req1 = 1'b0;
    req0 = 1'b1;
    sample();
    checks++;
    if ({gnt0, gnt1} !== 2'b01) begin
      errors++;
      $display("FAIL handoff_before: got %b expected 01", {gnt0, gnt1});
    end
    cycle();
    sample();
    checks++;
    if ({gnt0, gnt1, s, valid} !== 4'b1001) begin
      errors++;
      $display("FAIL handoff_direct: got %b expected 1001", {gnt0, gnt1, s, valid});
    end
  endtask

  task automatic test_reset_midburst();
    do_reset();
    req0 = 1'b1;
    req1 = 1'b1;
    ready = 1'b1;
    x1 = 8'h77;
    x2 = 8'h88;
    for (int k = 1; k <= 7; k++) cycle();
    sample();
    checks++;
    if ({gnt0, gnt1} !== 2'b01) begin
      errors++;
      $display("FAIL mid_in_gnt1: got %b expected 01", {gnt0, gnt1});
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({gnt0, gnt1, s, valid} !== 4'b0000 || f !== 8'h77) begin
      errors++;
      $display("FAIL mid_async: got %b f=%h expected 0000 f=77", {gnt0, gnt1, s, valid}, f);
    end
    cycle();
    cycle();
    rst_n = 1'b1;
    sample();
    checks++;
    if ({gnt0, gnt1, valid} !== 3'b000) begin
      errors++;
      $display("FAIL mid_idle: got %b expected 000", {gnt0, gnt1, valid});
    end
    cycle();
    sample();
    checks++;
    if ({gnt0, gnt1} !== 2'b10) begin
      errors++;
      $display("FAIL mid_first_src0: got %b expected 10", {gnt0, gnt1});
    end
  endtask

  task automatic test_burst1();
    logic es;
    do_reset();
    req0 = 1'b1;
    req1 = 1'b1;
    ready = 1'b1;
    x1 = 8'h01;
    x2 = 8'h02;
    for (int k = 1; k <= 6; k++) begin
      cycle();
      sample();
      es = ((k - 1) % 2) == 1;
      checks++;
      if ({gnt0_b, gnt1_b, s_b, valid_b} !== {~es, es, es, 1'b1} || f_b !== (es ? 8'h02 : 8'h01)) begin
        errors++;
        $display("FAIL b1_cycle%0d: got %b f=%h expected %b", k,
                 {gnt0_b, gnt1_b, s_b, valid_b}, f_b, {~es, es, es, 1'b1});
      end
    end
  endtask

  initial begin
    test_reset();
    test_alternate();
    test_backpressure();
    test_req1_only();
    test_handoff();
    test_reset_midburst();
    test_burst1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
